// File: rtl/eth_halfwidth_tx.sv
// 148-bit two-lane Avalon-ST beats to 64-bit data + 10-bit tag words for the MAC TX side.
// Optional protocol checker enabled by defining HALFWIDTH_PROTO_CHECK_EN.
module eth_halfwidth_tx #(
    parameter int unsigned LANEW = 74,
    parameter int unsigned TAGW  = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2*LANEW-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic                 in_empty,
    input  logic [2:0]           in_byte_empty,
    output logic [LANEW-TAGW-1:0] out_data,
    output logic [TAGW-1:0]      out_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic [2:0]           out_empty,
    output logic                 proto_err
);

    localparam int unsigned DATAW = LANEW - TAGW;

    typedef enum logic [1:0] {S_EMPTY, S_LANE0, S_LANE1} state_t;

    state_t            state_q, state_d;
    logic [LANEW-1:0]  lane0_q, lane0_d;
    logic [LANEW-1:0]  lane1_q, lane1_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              emp_q, emp_d;
    logic [2:0]        be_q, be_d;

    logic [DATAW-1:0]  out_data_q, out_data_d;
    logic [TAGW-1:0]   out_tag_q, out_tag_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic [2:0]        out_empty_q, out_empty_d;

    logic              lane1_unused;
    logic              last_lane;
    logic              in_fire;
    logic              out_fire;
    logic [LANEW-1:0]  lane_sel;

    // Next state, hold-register load and next output word
    always_comb begin
        state_d     = state_q;
        lane0_d     = lane0_q;
        lane1_d     = lane1_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        emp_d       = emp_q;
        be_d        = be_q;
        out_data_d  = '0;
        out_tag_d   = '0;
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        out_empty_d = 3'b0;
        lane_sel    = '0;

        lane1_unused = eop_q & emp_q;
        last_lane    = (state_q == S_LANE1) || ((state_q == S_LANE0) && lane1_unused);
        in_ready     = !reset && ((state_q == S_EMPTY) || (last_lane && out_ready));
        in_fire      = in_valid && in_ready;
        out_fire     = out_valid_q && out_ready;

        if (out_fire) begin
            state_d = last_lane ? S_EMPTY : S_LANE1;
        end
        if (in_fire) begin
            lane0_d = in_data[LANEW-1:0];
            lane1_d = in_data[2*LANEW-1:LANEW];
            sop_d   = in_sop;
            eop_d   = in_eop;
            emp_d   = in_empty;
            be_d    = in_byte_empty;
            state_d = S_LANE0;
        end

        // Outputs follow the post-transition state so they stay registered and stall-stable
        if (state_d != S_EMPTY) begin
            lane_sel    = (state_d == S_LANE1) ? lane1_d : lane0_d;
            out_valid_d = 1'b1;
            out_data_d  = lane_sel[DATAW-1:0];
            out_tag_d   = lane_sel[LANEW-1:DATAW];
            out_sop_d   = (state_d == S_LANE0) && sop_d;
            out_eop_d   = (state_d == S_LANE1) ? eop_d : (eop_d && emp_d);
            out_empty_d = out_eop_d ? be_d : 3'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            lane0_q     <= '0;
            lane1_q     <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            emp_q       <= 1'b0;
            be_q        <= 3'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= 3'b0;
        end else begin
            state_q     <= state_d;
            lane0_q     <= lane0_d;
            lane1_q     <= lane1_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            emp_q       <= emp_d;
            be_q        <= be_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_empty = out_empty_q;

`ifdef HALFWIDTH_PROTO_CHECK_EN
    logic in_pkt_q, in_pkt_d;
    logic proto_err_q, proto_err_d;

    // sop must arrive exactly when no packet is open
    always_comb begin
        in_pkt_d    = in_pkt_q;
        proto_err_d = proto_err_q;
        if (in_fire) begin
            if (in_sop == in_pkt_q) begin
                proto_err_d = 1'b1;
            end
            in_pkt_d = !in_eop;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_pkt_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            in_pkt_q    <= in_pkt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule
